// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: h/v counters, drawer-latency delay line for video flags, registered VGA outputs.
// Optional macro VGA_BORDER_EN paints a white one-pixel frame around the active area.
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 1,
    parameter logic [3:0]  BG_R     = 4'h0,
    parameter logic [3:0]  BG_G     = 4'h0,
    parameter logic [3:0]  BG_B     = 4'h4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  Red_in,
    input  logic [3:0]  Green_in,
    input  logic [3:0]  Blue_in,
    input  logic        Draw_in,
    output logic [31:0] pxl_x,
    output logic [31:0] pxl_y,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned CW      = 12;

    // Flag vector layout: [0] active, [1] hsync_n, [2] vsync_n, [3] border (optional)
    localparam int unsigned FLAG_ACT = 0;
    localparam int unsigned FLAG_HS  = 1;
    localparam int unsigned FLAG_VS  = 2;
`ifdef VGA_BORDER_EN
    localparam int unsigned FLAG_BRD = 3;
    localparam int unsigned FW       = 4;
`else
    localparam int unsigned FW       = 3;
`endif
    localparam logic [FW-1:0] FLAG_IDLE = FW'(3'b110);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [FW-1:0] flag_cur;
    logic [FW-1:0] flag_dly;
    logic [CW-1:0] rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    // Scan counters: h wraps every line, v advances on each h wrap
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        flag_cur           = FLAG_IDLE;
        flag_cur[FLAG_ACT] = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        flag_cur[FLAG_HS]  = !((h_q >= HW'(HS_BEG)) && (h_q < HW'(HS_END)));
        flag_cur[FLAG_VS]  = !((v_q >= VW'(VS_BEG)) && (v_q < VW'(VS_END)));
`ifdef VGA_BORDER_EN
        flag_cur[FLAG_BRD] = flag_cur[FLAG_ACT] &&
                             ((h_q == '0) || (h_q == HW'(H_ACTIVE - 1)) ||
                              (v_q == '0) || (v_q == VW'(V_ACTIVE - 1)));
`endif
    end

    // Delay line matching the drawer latency so flags meet the colour of the same coordinate
    if (PIPE_DLY == 0) begin : g_no_dly
        assign flag_dly = flag_cur;
    end else begin : g_dly
        logic [FW-1:0] dly_q [PIPE_DLY];
        logic [FW-1:0] dly_d [PIPE_DLY];

        always_comb begin
            dly_d[0] = flag_cur;
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    dly_q[i] <= FLAG_IDLE;
                end
            end else begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    dly_q[i] <= dly_d[i];
                end
            end
        end

        assign flag_dly = dly_q[PIPE_DLY-1];
    end

    // Colour select: blank outside active video, drawer colour when claimed, else background
    always_comb begin
        rgb_d = {BG_R, BG_G, BG_B};
        if (!flag_dly[FLAG_ACT]) begin
            rgb_d = '0;
        end else if (Draw_in) begin
            rgb_d = {Red_in, Green_in, Blue_in};
        end
`ifdef VGA_BORDER_EN
        if (flag_dly[FLAG_BRD]) begin
            rgb_d = 12'hFFF;
        end
`endif
        hsync_d = flag_dly[FLAG_HS];
        vsync_d = flag_dly[FLAG_VS];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign pxl_x       = 32'(h_q);
    assign pxl_y       = 32'(v_q);
    assign frame_start = (h_q == '0) && (v_q == '0);
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a scaled-down raster (80x30 clocks/lines) to keep runs short.
// Expected border pixels are added when VGA_BORDER_EN is defined for the build.
module tb_vga_scan_ctrl;

    localparam int unsigned H_ACTIVE = 64;
    localparam int unsigned H_FP     = 4;
    localparam int unsigned H_SYNC   = 8;
    localparam int unsigned H_BP     = 4;
    localparam int unsigned V_ACTIVE = 24;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int unsigned P        = 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME    = H_TOTAL * V_TOTAL;
    localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
    localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
    localparam int          PX       = 10;
    localparam int          PY       = 5;
    localparam logic [11:0] BG       = 12'h004;
    localparam logic [13:0] IDLE     = 14'b0000_0000_0000_11;
`ifdef VGA_BORDER_EN
    localparam int unsigned RED_PER_FRAME = 1 + 2 * H_ACTIVE + 2 * V_ACTIVE - 4;
`else
    localparam int unsigned RED_PER_FRAME = 1;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  Red_in, Green_in, Blue_in;
    logic        Draw_in;
    logic [31:0] pxl_x, pxl_y;
    logic        frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync;

    vga_scan_ctrl #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .PIPE_DLY (P)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .Red_in      (Red_in),
        .Green_in    (Green_in),
        .Blue_in     (Blue_in),
        .Draw_in     (Draw_in),
        .pxl_x       (pxl_x),
        .pxl_y       (pxl_y),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: expected coordinate, pending expected outputs, pending drawer responses
    int          mh, mv;
    logic [13:0] exp_q [$];
    logic [12:0] resp_q [$];
    int          win_cycles, win_mode, vs_low, red_cnt, hs_run;
    logic        hs_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] model_pix(input int x, input int y, input logic [12:0] r);
        logic        act, hs, vs;
        logic [11:0] col;
        act = (x < int'(H_ACTIVE)) && (y < int'(V_ACTIVE));
        hs  = !((x >= int'(HS_BEG)) && (x < int'(HS_BEG + H_SYNC)));
        vs  = !((y >= int'(VS_BEG)) && (y < int'(VS_BEG + V_SYNC)));
        col = !act ? 12'h000 : (r[12] ? r[11:0] : BG);
`ifdef VGA_BORDER_EN
        if (act && (x == 0 || x == int'(H_ACTIVE) - 1 || y == 0 || y == int'(V_ACTIVE) - 1))
            col = 12'hFFF;
`endif
        return {col, hs, vs};
    endfunction

    task automatic restart_model();
        mh = 0;
        mv = 0;
        exp_q.delete();
        resp_q.delete();
        for (int i = 0; i < int'(P) + 1; i++) exp_q.push_back(IDLE);
        for (int i = 0; i < int'(P); i++) resp_q.push_back(13'h0);
        win_cycles = 0;
        win_mode   = 0;
        vs_low     = 0;
        red_cnt    = 0;
        hs_run     = 0;
        hs_prev    = 1'b1;
    endtask

    task automatic reset_value_checks();
        check("rst_pxl_x", pxl_x, 32'd0);
        check("rst_pxl_y", pxl_y, 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd1);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_syncs", 32'({hsync, vsync}), 32'd3);
    endtask

    // One pixel clock: compare coordinate and the output due now, drive drawer, advance model
    task automatic step(input int mode);
        logic [12:0] r, d;
        logic [13:0] e;
        check("pxl_x", pxl_x, 32'(mh));
        check("pxl_y", pxl_y, 32'(mv));
        check("frame_start", 32'(frame_start), 32'(mh == 0 && mv == 0));
        case (mode)
            0:       r = {1'b0, 12'($urandom)};
            1:       r = (mh == PX && mv == PY) ? {1'b1, 12'hF00} : {1'b0, 12'($urandom)};
            2:       r = {1'b1, 12'hFFF};
            default: r = 13'($urandom);
        endcase
        resp_q.push_back(r);
        d = resp_q.pop_front();
        {Draw_in, Red_in, Green_in, Blue_in} = d;
        exp_q.push_back(model_pix(mh, mv, r));
        e = exp_q.pop_front();
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[13:2]));
        check("hsync", 32'(hsync), 32'(e[1]));
        check("vsync", 32'(vsync), 32'(e[0]));

        if (mh == int'(HS_BEG + P + 1)) check("hs_fall", 32'({hs_prev, hsync}), 32'd2);
        if (!hsync) hs_run++;
        else if (hs_run != 0) begin
            check("hs_low_clocks", 32'(hs_run), 32'(H_SYNC));
            hs_run = 0;
        end
        hs_prev = hsync;

        if (mh == 0 && mv == 0) begin
            if (win_cycles == int'(FRAME)) begin
                check("vs_low_clocks", 32'(vs_low), 32'(V_SYNC * H_TOTAL));
                if (win_mode == 1) check("red_pixels", 32'(red_cnt), 32'(RED_PER_FRAME));
            end
            win_cycles = 0;
            vs_low     = 0;
            red_cnt    = 0;
            win_mode   = mode;
        end
        win_cycles++;
        if (!vsync) vs_low++;
        if (vga_r == 4'hF) red_cnt++;

        if (mh == int'(H_TOTAL) - 1) begin
            mh = 0;
            mv = (mv == int'(V_TOTAL) - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic run_frames(input int mode, input int n);
        for (int i = 0; i < n * int'(FRAME); i++) begin
            step(mode);
            @(negedge clk);
        end
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int cur_h, cur_v;
        resetN   = 1'b0;
        Draw_in  = 1'b0;
        Red_in   = 4'h0;
        Green_in = 4'h0;
        Blue_in  = 4'h0;
        restart_model();
        repeat (3) @(negedge clk);
        reset_value_checks();

        resetN = 1'b1;
        run_frames(3, 1);
        run_frames(1, 2);
        run_frames(2, 1);

        // Free-run until both syncs are low, then pull reset between clock edges
        found = 1'b0;
        for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
            cur_h = mh;
            cur_v = mv;
            step(0);
            if (cur_h == int'(HS_BEG) + 3 && cur_v == int'(VS_BEG) + 1) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_point_reached", 32'(found), 32'd1);
        check("pre_rst_syncs", 32'({hsync, vsync}), 32'd0);
        #1 resetN = 1'b0;
        #1 reset_value_checks();

        repeat (3) @(negedge clk);
        reset_value_checks();
        restart_model();
        resetN = 1'b1;
        run_frames(3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
